// File: rtl/vertigo_datatypes.sv
// Shared Valinor/Vertigo scheduler types: default sublist geometry, infinity markers,
// the SublistElement packing and the per-sublist summary seen by the pointer list.
package vertigo_datatypes;

  localparam int SUBLIST_DEPTH = 8;
  localparam int SL_ID_W       = 6;
  localparam int SL_RANK_W     = 16;
  localparam int SL_TIME_W     = 16;

  localparam logic [SL_RANK_W-1:0] RANK_INF = '1;
  localparam logic [SL_TIME_W-1:0] TIME_INF = '1;

  typedef struct packed {
    logic [SL_ID_W-1:0]   id;
    logic [SL_RANK_W-1:0] rank;
    logic [SL_TIME_W-1:0] send_time;
  } SublistElement;

  typedef struct packed {
    logic [SL_RANK_W-1:0]                   smallest_rank;
    logic [SL_TIME_W-1:0]                   smallest_send_time;
    logic                                   full;
    logic [$clog2(SUBLIST_DEPTH+1)-1:0]     num;
  } SublistSummary;

endpackage

// File: rtl/sublist_eligible_select.sv
// Combinational priority encoder: index of the lowest valid slot whose send_time has
// been reached (or simply the lowest valid slot when time gating is off).
module sublist_eligible_select
  import vertigo_datatypes::*;
#(
  parameter int DEPTH      = SUBLIST_DEPTH,
  parameter int TIME_W     = SL_TIME_W,
  parameter int TIME_GATED = 1,
  parameter int IDX_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [TIME_W-1:0] send_time [DEPTH],
  input  logic [TIME_W-1:0] now,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [DEPTH-1:0] eligible;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
    assign eligible[gi] = valid[gi] && ((TIME_GATED == 0) || (send_time[gi] <= now));
  end

  // Scan downwards so the lowest eligible index is the last one written.
  always_comb begin
    hit = |eligible;
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/sublist_sorted_buffer.sv
// Rank-sorted, time-gated sublist: single-cycle sorted insert, dequeue of the lowest-rank
// eligible entry, and a live summary (head rank, earliest send_time, occupancy).
module sublist_sorted_buffer
  import vertigo_datatypes::*;
#(
  parameter int DEPTH      = SUBLIST_DEPTH,
  parameter int ID_W       = SL_ID_W,
  parameter int RANK_W     = SL_RANK_W,
  parameter int TIME_W     = SL_TIME_W,
  parameter int TIME_GATED = 1,
  parameter int ELEM_W     = ID_W + RANK_W + TIME_W,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [ELEM_W-1:0] enq_elem,
  input  logic              deq_req,
  input  logic [TIME_W-1:0] now,
  output logic              deq_valid,
  output logic [ELEM_W-1:0] deq_elem,
  output logic              deq_miss,
  output logic [RANK_W-1:0] smallest_rank,
  output logic [TIME_W-1:0] smallest_send_time,
  output logic [CNT_W-1:0]  num,
  output logic              full,
  output logic              empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [ID_W-1:0]   id_reg   [DEPTH];
  logic [RANK_W-1:0] rank_reg [DEPTH];
  logic [TIME_W-1:0] time_reg [DEPTH];
  logic [DEPTH-1:0]  valid_reg;
  logic [CNT_W-1:0]  num_reg;
  logic              deq_valid_reg, deq_miss_reg;
  logic [ELEM_W-1:0] deq_elem_reg;

  logic [ID_W-1:0]   rm_id   [DEPTH];
  logic [RANK_W-1:0] rm_rank [DEPTH];
  logic [TIME_W-1:0] rm_time [DEPTH];
  logic [DEPTH-1:0]  rm_valid;
  logic [ID_W-1:0]   id_next   [DEPTH];
  logic [RANK_W-1:0] rank_next [DEPTH];
  logic [TIME_W-1:0] time_next [DEPTH];
  logic [DEPTH-1:0]  valid_next;
  logic [DEPTH-1:0]  shift_down, ins_here, at_or_after;
  logic [CNT_W-1:0]  num_next;

  logic [ID_W-1:0]   enq_id;
  logic [RANK_W-1:0] enq_rank;
  logic [TIME_W-1:0] enq_time;
  logic              sel_hit, deq_fire, enq_fire;
  logic [IDX_W-1:0]  sel_idx;
  logic [TIME_W-1:0] min_time;

  assign {enq_id, enq_rank, enq_time} = enq_elem;

  sublist_eligible_select #(
    .DEPTH(DEPTH), .TIME_W(TIME_W), .TIME_GATED(TIME_GATED), .IDX_W(IDX_W)
  ) u_select (
    .valid(valid_reg), .send_time(time_reg), .now(now), .hit(sel_hit), .idx(sel_idx)
  );

  assign full      = (num_reg == CNT_W'(DEPTH));
  assign empty     = (num_reg == '0);
  assign enq_ready = !full;
  assign deq_fire  = deq_req && sel_hit;
  assign enq_fire  = enq_valid && enq_ready;

  // Removal first, then the sorted insert into the post-removal array.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign shift_down[gi] = deq_fire && (IDX_W'(gi) >= sel_idx);
    if (gi == DEPTH - 1) begin : g_top
      assign rm_id[gi]    = shift_down[gi] ? '0 : id_reg[gi];
      assign rm_rank[gi]  = shift_down[gi] ? '1 : rank_reg[gi];
      assign rm_time[gi]  = shift_down[gi] ? '1 : time_reg[gi];
      assign rm_valid[gi] = shift_down[gi] ? 1'b0 : valid_reg[gi];
    end else begin : g_mid
      assign rm_id[gi]    = shift_down[gi] ? id_reg[gi+1]    : id_reg[gi];
      assign rm_rank[gi]  = shift_down[gi] ? rank_reg[gi+1]  : rank_reg[gi];
      assign rm_time[gi]  = shift_down[gi] ? time_reg[gi+1]  : time_reg[gi];
      assign rm_valid[gi] = shift_down[gi] ? valid_reg[gi+1] : valid_reg[gi];
    end

    // Strictly greater keeps equal ranks in arrival order.
    assign ins_here[gi] = !rm_valid[gi] || (rm_rank[gi] > enq_rank);

    if (gi == 0) begin : g_first
      assign at_or_after[gi] = ins_here[gi];
      assign id_next[gi]    = (enq_fire && at_or_after[gi]) ? enq_id   : rm_id[gi];
      assign rank_next[gi]  = (enq_fire && at_or_after[gi]) ? enq_rank : rm_rank[gi];
      assign time_next[gi]  = (enq_fire && at_or_after[gi]) ? enq_time : rm_time[gi];
      assign valid_next[gi] = (enq_fire && at_or_after[gi]) ? 1'b1     : rm_valid[gi];
    end else begin : g_rest
      logic is_pos;
      assign at_or_after[gi] = at_or_after[gi-1] | ins_here[gi];
      assign is_pos          = at_or_after[gi] && !at_or_after[gi-1];
      always_comb begin
        id_next[gi]    = rm_id[gi];
        rank_next[gi]  = rm_rank[gi];
        time_next[gi]  = rm_time[gi];
        valid_next[gi] = rm_valid[gi];
        if (enq_fire && is_pos) begin
          id_next[gi]    = enq_id;
          rank_next[gi]  = enq_rank;
          time_next[gi]  = enq_time;
          valid_next[gi] = 1'b1;
        end else if (enq_fire && at_or_after[gi]) begin
          id_next[gi]    = rm_id[gi-1];
          rank_next[gi]  = rm_rank[gi-1];
          time_next[gi]  = rm_time[gi-1];
          valid_next[gi] = rm_valid[gi-1];
        end
      end
    end
  end

  always_comb begin
    num_next = num_reg;
    if (enq_fire && !deq_fire)      num_next = num_reg + 1'b1;
    else if (!enq_fire && deq_fire) num_next = num_reg - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_reg[i]   <= '0;
        rank_reg[i] <= '1;
        time_reg[i] <= '1;
      end
      valid_reg     <= '0;
      num_reg       <= '0;
      deq_valid_reg <= 1'b0;
      deq_miss_reg  <= 1'b0;
      deq_elem_reg  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        id_reg[i]   <= id_next[i];
        rank_reg[i] <= rank_next[i];
        time_reg[i] <= time_next[i];
      end
      valid_reg     <= valid_next;
      num_reg       <= num_next;
      deq_valid_reg <= deq_fire;
      deq_miss_reg  <= deq_req && !sel_hit;
      if (deq_fire) deq_elem_reg <= {id_reg[sel_idx], rank_reg[sel_idx], time_reg[sel_idx]};
    end
  end

  always_comb begin
    min_time = '1;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_reg[i] && (time_reg[i] < min_time)) min_time = time_reg[i];
    end
  end

  assign smallest_rank      = rank_reg[0];
  assign smallest_send_time = min_time;
  assign num                = num_reg;
  assign deq_valid          = deq_valid_reg;
  assign deq_miss           = deq_miss_reg;
  assign deq_elem           = deq_elem_reg;

  a_num_bound : assert property (@(posedge clk) disable iff (rst) num_reg <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_sublist_sorted_buffer.sv
// Directed bench for sublist_sorted_buffer: sorted insert with FIFO ties, fill/full
// blocking, time-gated dequeue, simultaneous enq+deq and reset during a pending result.
module tb_sublist_sorted_buffer;

  localparam int ID_W   = 6;
  localparam int RANK_W = 16;
  localparam int TIME_W = 16;
  localparam int ELEM_W = ID_W + RANK_W + TIME_W;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_valid;
  logic              enq_ready;
  logic [ELEM_W-1:0] enq_elem;
  logic              deq_req;
  logic [TIME_W-1:0] now;
  logic              deq_valid;
  logic [ELEM_W-1:0] deq_elem;
  logic              deq_miss;
  logic [RANK_W-1:0] smallest_rank;
  logic [TIME_W-1:0] smallest_send_time;
  logic [CNT_W-1:0]  num;
  logic              full;
  logic              empty;

  int tests_run = 0;
  int tests_failed = 0;

  sublist_sorted_buffer dut (
    .clk(clk), .rst(rst), .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_elem(enq_elem),
    .deq_req(deq_req), .now(now), .deq_valid(deq_valid), .deq_elem(deq_elem),
    .deq_miss(deq_miss), .smallest_rank(smallest_rank), .smallest_send_time(smallest_send_time),
    .num(num), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enq_valid = 1'b0;
    deq_req = 1'b0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic enq(input int id, input int rank, input int t);
    enq_valid = 1'b1;
    enq_elem  = {ID_W'(id), RANK_W'(rank), TIME_W'(t)};
    step();
    enq_valid = 1'b0;
  endtask

  task automatic deq_expect(input string tag, input int t_now, input int exp_id);
    logic [ID_W-1:0] got_id;
    now = TIME_W'(t_now);
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    got_id = deq_elem[ELEM_W-1 -: ID_W];
    check({tag, "_valid"}, 64'(deq_valid), 64'd1);
    check({tag, "_id"}, 64'(got_id), 64'(exp_id));
  endtask

  initial begin
    rst = 1'b1;
    enq_valid = 1'b0;
    enq_elem = '0;
    deq_req = 1'b0;
    now = '0;
    step();
    #2;
    check("rst_num", 64'(num), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_enq_ready", 64'(enq_ready), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_smallest_rank", 64'(smallest_rank), 64'hFFFF);
    check("rst_smallest_time", 64'(smallest_send_time), 64'hFFFF);
    check("rst_deq_valid", 64'(deq_valid), 64'd0);
    check("rst_deq_miss", 64'(deq_miss), 64'd0);
    rst = 1'b0;
    step();

    // Sorted insert with FIFO among equal ranks
    enq(1, 5, 0); enq(2, 2, 0); enq(3, 9, 0); enq(4, 2, 0);
    check("sort_num", 64'(num), 64'd4);
    check("sort_smallest_rank", 64'(smallest_rank), 64'd2);
    check("sort_smallest_time", 64'(smallest_send_time), 64'd0);
    deq_expect("sort_deq0", 0, 2);
    deq_expect("sort_deq1", 0, 4);
    deq_expect("sort_deq2", 0, 1);
    deq_expect("sort_deq3", 0, 3);
    check("sort_empty", 64'(empty), 64'd1);

    // Fill to full; extra enqueue must be dropped
    do_reset();
    for (int i = 0; i < 8; i++) enq(10 + i, 10 + i, 0);
    check("full_flag", 64'(full), 64'd1);
    check("full_enq_ready", 64'(enq_ready), 64'd0);
    enq(63, 0, 0);
    check("full_num_after_9th", 64'(num), 64'd8);
    check("full_rank_after_9th", 64'(smallest_rank), 64'd10);
    deq_expect("full_deq", 0, 10);
    check("full_enq_ready_after_deq", 64'(enq_ready), 64'd1);
    check("full_num_after_deq", 64'(num), 64'd7);

    // Time gating
    do_reset();
    enq(1, 1, 100); enq(2, 3, 10);
    check("gate_smallest_time", 64'(smallest_send_time), 64'd10);
    deq_expect("gate_deq_now50", 50, 2);
    check("gate_time_after", 64'(smallest_send_time), 64'd100);
    now = 16'd50;
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    check("gate_miss", 64'(deq_miss), 64'd1);
    check("gate_miss_valid", 64'(deq_valid), 64'd0);
    check("gate_miss_num", 64'(num), 64'd1);
    deq_expect("gate_deq_now100", 100, 1);

    // Simultaneous enqueue and dequeue
    do_reset();
    enq(1, 2, 30); enq(2, 6, 20); enq(3, 8, 40);
    now = 16'd100;
    enq_valid = 1'b1;
    enq_elem = {ID_W'(4), RANK_W'(4), TIME_W'(5)};
    deq_req = 1'b1;
    step();
    enq_valid = 1'b0;
    deq_req = 1'b0;
    check("both_deq_valid", 64'(deq_valid), 64'd1);
    check("both_deq_id", 64'(deq_elem[ELEM_W-1 -: ID_W]), 64'd1);
    check("both_num", 64'(num), 64'd3);
    check("both_smallest_rank", 64'(smallest_rank), 64'd4);
    check("both_smallest_time", 64'(smallest_send_time), 64'd5);
    // A missing dequeue does not block the insert
    now = 16'd0;
    enq_valid = 1'b1;
    enq_elem = {ID_W'(5), RANK_W'(7), TIME_W'(9)};
    deq_req = 1'b1;
    step();
    enq_valid = 1'b0;
    deq_req = 1'b0;
    check("both_miss", 64'(deq_miss), 64'd1);
    check("both_miss_num", 64'(num), 64'd4);
    deq_expect("both_order0", 100, 4);
    deq_expect("both_order1", 100, 2);
    deq_expect("both_order2", 100, 5);
    deq_expect("both_order3", 100, 3);

    // Empty dequeue, then reset while a result is pending
    do_reset();
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    check("empty_miss", 64'(deq_miss), 64'd1);
    check("empty_valid", 64'(deq_valid), 64'd0);
    enq(7, 3, 0);
    now = 16'd0;
    deq_req = 1'b1;
    step();
    deq_req = 1'b0;
    check("pending_valid", 64'(deq_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_deq_valid", 64'(deq_valid), 64'd0);
    check("midrst_deq_elem", 64'(deq_elem), 64'd0);
    check("midrst_num", 64'(num), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_smallest_rank", 64'(smallest_rank), 64'hFFFF);
    check("midrst_smallest_time", 64'(smallest_send_time), 64'hFFFF);
    step();
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
